controller_poller: RTL
======================

// Module: controller_poller
// PURPOSE
//  Parametrised successor to the 2-pad controller interface. Polls NUM_CONTROLLERS NES/SNES-style
//  serial pads in lockstep with one shared latch/clock pair, and presents each pad's byte/word
//  to the memory map atomically. Adds per-pad plug detection, sticky "new press" flags with
//  per-pad acknowledge, and start-edge detection. Sits between the GPU start-fetch strobe and
//  the CPU-visible controller registers.
// PARAMETERS
//  NUM_CONTROLLERS      4   number of pads sharing latch/clock
//  BITS_PER_CONTROLLER  8   data bits per pad (8 = NES, 16 = SNES); must be >= 2
//  LATCH_PULSE_WIDTH    2   latch_o high time, clk cycles, >= 1
//  CLK_DIV              1   clk cycles per clk_o half-period, >= 1
// PORTS
//  clk              in   1      poll clock
//  rst              in   1      async active-high reset
//  start_fetch_i    in   1      fetch request; rising edge starts one poll
//  clk_o            out  1      pad clock, idles high
//  latch_o          out  1      pad latch, active high
//  serial_LIST_ni   in   N      pad serial data, active low, bit k = pad k
//  data_LIST_o      out  N*B    button state, active high, slot k = bits [k*B +: B]
//  pressed_LIST_o   out  N*B    sticky 0->1 transitions since last ack, same layout
//  ack_i            in   N      ack_i[k] clears pressed slot k
//  connected_o      out  N      pad k answered last poll
//  busy_o           out  1      poll in progress
//  done_o           out  1      one-cycle pulse on commit
// BEHAVIOUR
//  Reset: state IDLE, all counters 0, clk_o=1, latch_o=0, data/pressed/connected=0, busy_o=0,
//   done_o=0, start edge register=0. Reset mid-poll aborts immediately; no partial commit.
//  Start: start_q registers start_fetch_i; go = start_fetch_i & ~start_q. go in IDLE -> LATCH.
//   go outside IDLE is dropped (no queueing); held-high start fires once only.
//  FSM: IDLE -> LATCH (LATCH_PULSE_WIDTH cycles, latch_o=1) -> {PULSE_LO (CLK_DIV cycles,
//   clk_o=0) -> PULSE_HI (CLK_DIV cycles, clk_o=1)} x B -> COMMIT (1 cycle) -> IDLE.
//  busy_o = (state != IDLE). clk_o = 1 in every state except PULSE_LO.
//  Sampling: sample ~serial_LIST_ni[k] into shift reg k on the last LATCH cycle (bit 0) and
//   on the last PULSE_HI cycle of pulses 1..B-1 (bits 1..B-1), shifting left: first sample ends
//   in slot MSB. Pulse B's last PULSE_HI cycle samples the detect bit: a present pad has shifted
//   out its ground-tied serial input, so its line is driven low (the sample reads 1); an absent
//   pad's pulled-up line reads 0.
//  COMMIT (one cycle, all pads simultaneously): connected_o[k] <= detect sample. data slot k <=
//   shift reg k if connected, else 0. new_k = next_data_k & ~cur_data_k.
//   pressed_k <= (pressed_k & ~{B{ack_i[k]}}) | new_k; the new press wins over a same-cycle ack.
//   done_o=1.
//  ack_i outside COMMIT: pressed_k <= 0 next cycle. data_LIST_o and connected_o change only in COMMIT.
//  Latency: go at edge 0 -> latch_o high for edges 1..L -> done_o high on cycle
//   L + 2*B*CLK_DIV + 1. Default: 2+16+1 = 19.
//   Poll period is unconstrained; back-to-back polls need one IDLE cycle between.
// STRUCTURE
//  mapache64 package: controller_poll_state_t enum {IDLE, LATCH, PULSE_LO, PULSE_HI, COMMIT}.
//  Counter widths are $clog2-derived locally from the parameters.
//  Sub-module controller_shift_lane (one per pad, generate loop): B+1-bit shift reg, sample_en
//   and commit inputs; outputs data, detect and new-press vector. The top holds the FSM, the
//   phase/bit counters and the start-edge register.
// TESTING
//  1. Reset, start pulse, pad0 model button pattern 8'b1010_0001 (N=4, B=8, CLK_DIV=1) ->
//     latch_o 2 cycles, 8 low pulses on clk_o, done_o at cycle 19, data slot0=8'hA1, pressed slot0=8'hA1.
//  2. Pad2 line tied high (absent) -> connected_o=4'b1011, data slot2=0, pressed slot2 unchanged.
//  3. Second poll with pad0 = 8'hA3 and no ack -> pressed slot0=8'hA3; ack_i[0] pulse -> slot0=0.
//     Then ack_i[0] in the COMMIT cycle of a 8'h00->8'h04 change -> pressed slot0=8'h04.
//  4. Start held high 50 cycles, extra start pulse mid-poll -> exactly one done_o; busy_o high
//     cycles 1..19.
//  5. rst asserted during PULSE_HI of bit 4 -> outputs return to reset values immediately;
//     next start gives full, correct poll.
//  6. B=16, CLK_DIV=3, L=1 -> done_o at cycle 1+96+1 = 98; pad word 16'hC00F read back intact.

Source files
------------

// File: rtl/mapache64_pkg.sv
// Shared types for the controller poller.
package mapache64_pkg;

    // Poll sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        PULSE_LO,
        PULSE_HI,
        COMMIT
    } controller_poll_state_t;

endpackage

// File: rtl/controller_poller_shift_lane.sv
// One pad's serial capture lane: shift register, committed button state,
// plug detection and sticky new-press flags.
module controller_shift_lane #(
    parameter int B = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sample_en,
    input  logic         commit,
    input  logic         serial_ni,
    input  logic         ack_i,
    output logic [B-1:0] data_o,
    output logic [B-1:0] pressed_o,
    output logic         detect_o
);

    // shift_q[B:1] holds the buttons (first sample in the MSB), shift_q[0] the detect bit.
    logic [B:0]   shift_q, shift_d;
    logic [B-1:0] data_q, data_d;
    logic [B-1:0] pressed_q, pressed_d;
    logic [B-1:0] new_press;
    logic         conn_q, conn_d;

    // Capture samples, and on commit publish the word and fold in new presses.
    always_comb begin
        shift_d   = shift_q;
        data_d    = data_q;
        pressed_d = pressed_q;
        conn_d    = conn_q;
        new_press = '0;
        if (sample_en) begin
            shift_d = {shift_q[B-1:0], ~serial_ni};
        end
        if (commit) begin
            conn_d    = shift_q[0];
            data_d    = shift_q[0] ? shift_q[B:1] : '0;
            new_press = data_d & ~data_q;
            // A fresh press survives an ack arriving in the same cycle.
            pressed_d = (pressed_q & ~{B{ack_i}}) | new_press;
        end else if (ack_i) begin
            pressed_d = '0;
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q   <= '0;
            data_q    <= '0;
            pressed_q <= '0;
            conn_q    <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            data_q    <= data_d;
            pressed_q <= pressed_d;
            conn_q    <= conn_d;
        end
    end

    assign data_o    = data_q;
    assign pressed_o = pressed_q;
    assign detect_o  = conn_q;

endmodule

// File: rtl/controller_poller.sv
// Polls several serial game pads in lockstep over one shared latch/clock pair
// and commits all pads' button words at once.
module controller_poller
    import mapache64_pkg::*;
#(
    parameter int NUM_CONTROLLERS     = 4,
    parameter int BITS_PER_CONTROLLER = 8,
    parameter int LATCH_PULSE_WIDTH   = 2,
    parameter int CLK_DIV             = 1
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           start_fetch_i,
    output logic                                           clk_o,
    output logic                                           latch_o,
    input  logic [NUM_CONTROLLERS-1:0]                     serial_LIST_ni,
    output logic [NUM_CONTROLLERS*BITS_PER_CONTROLLER-1:0] data_LIST_o,
    output logic [NUM_CONTROLLERS*BITS_PER_CONTROLLER-1:0] pressed_LIST_o,
    input  logic [NUM_CONTROLLERS-1:0]                     ack_i,
    output logic [NUM_CONTROLLERS-1:0]                     connected_o,
    output logic                                           busy_o,
    output logic                                           done_o
);

    localparam int B      = BITS_PER_CONTROLLER;
    localparam int PH_MAX = (LATCH_PULSE_WIDTH > CLK_DIV) ? LATCH_PULSE_WIDTH : CLK_DIV;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int BIT_W  = $clog2(B);

    controller_poll_state_t state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             start_q;
    logic             go;
    logic             sample_en;
    logic             commit;

    // Only a rising edge of the fetch strobe may launch a poll.
    assign go = start_fetch_i & ~start_q;

    // Sequencer: latch pulse, B clock pulses, then one commit cycle.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        sample_en = 1'b0;
        commit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = LATCH;
                    phase_d = '0;
                end
            end
            LATCH: begin
                if (phase_q == PH_W'(LATCH_PULSE_WIDTH - 1)) begin
                    sample_en = 1'b1;
                    state_d   = PULSE_LO;
                    phase_d   = '0;
                    bit_d     = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            PULSE_LO: begin
                if (phase_q == PH_W'(CLK_DIV - 1)) begin
                    state_d = PULSE_HI;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            PULSE_HI: begin
                if (phase_q == PH_W'(CLK_DIV - 1)) begin
                    sample_en = 1'b1;
                    phase_d   = '0;
                    if (bit_q == BIT_W'(B - 1)) begin
                        state_d = COMMIT;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        state_d = PULSE_LO;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer registers and start-edge register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            start_q <= start_fetch_i;
        end
    end

    assign clk_o   = (state_q != PULSE_LO);
    assign latch_o = (state_q == LATCH);
    assign busy_o  = (state_q != IDLE);
    assign done_o  = (state_q == COMMIT);

    generate
        for (genvar gi = 0; gi < NUM_CONTROLLERS; gi++) begin : g_lane
            controller_shift_lane #(.B(B)) u_lane (
                .clk       (clk),
                .rst       (rst),
                .sample_en (sample_en),
                .commit    (commit),
                .serial_ni (serial_LIST_ni[gi]),
                .ack_i     (ack_i[gi]),
                .data_o    (data_LIST_o[gi*B +: B]),
                .pressed_o (pressed_LIST_o[gi*B +: B]),
                .detect_o  (connected_o[gi])
            );
        end
    endgenerate

endmodule
